// File: rtl/except_ctrl.sv
// -----------------------------------------------------------------------------
// except_ctrl -- MEM-stage exception arbiter and pipeline redirect controller.
//
// Picks the highest-priority exception for the instruction in MEM (interrupt,
// reserved instruction, syscall, trap, overflow, eret), registers it and then
// walks a three-state sequence: IDLE -> FLUSH (one-cycle flush pulse with the
// exception record and redirect PC) -> BLANK (one dead cycle) -> IDLE.
// CP0 status/cause/epc/ebase are bypassed from a same-cycle WB write.
//
// Configuration macro: EXC_IRQ_SYNC_EN
//   defined   : int_i passes a two-flop synchroniser to int_o (2-cycle latency)
//   undefined : int_i is registered once into int_o (1-cycle latency)
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   mem_valid_i                MEM-stage instruction valid
//   mem_inst_addr_i            MEM-stage PC
//   mem_in_delayslot_i         MEM-stage instruction sits in a delay slot
//   inst_inval_i, syscall_i,
//   trap_i, overflow_i, eret_i MEM-stage fault/event flags
//   cp0_status_i .. ebase_i    architectural CP0 registers
//   wb_cp0_we_i/waddr_i/data_i WB-stage CP0 write for bypassing
//   int_i, timer_int_i         raw hardware interrupt lines, CP0 timer irq
//   excepttype_o               exception code, nonzero only during FLUSH
//   current_inst_addr_o        PC of the excepting instruction
//   is_in_delayslot_o          delay-slot flag of the excepting instruction
//   int_o                      conditioned hardware interrupt lines
//   flush_o                    pipeline flush pulse (FLUSH state)
//   new_pc_o                   redirect target, holds its last value
//   busy_o                     high in FLUSH or BLANK
// -----------------------------------------------------------------------------
module except_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_in_delayslot_i,
  input  logic        inst_inval_i,
  input  logic        syscall_i,
  input  logic        trap_i,
  input  logic        overflow_i,
  input  logic        eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic [31:0] cp0_ebase_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [5:0]  int_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  localparam logic [31:0] ExcNone      = 32'h0000_0000;
  localparam logic [31:0] ExcInterrupt = 32'h0000_0001;
  localparam logic [31:0] ExcSyscall   = 32'h0000_0008;
  localparam logic [31:0] ExcInstInval = 32'h0000_000a;
  localparam logic [31:0] ExcOverflow  = 32'h0000_000c;
  localparam logic [31:0] ExcTrap      = 32'h0000_000d;
  localparam logic [31:0] ExcEret      = 32'h0000_000e;

  localparam logic [4:0] AddrStatus = 5'd12;
  localparam logic [4:0] AddrCause  = 5'd13;
  localparam logic [4:0] AddrEpc    = 5'd14;
  localparam logic [4:0] AddrEbase  = 5'd15;

  localparam logic [31:0] VecOffset = 32'h0000_0180;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StBlank
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] code_q, code_d;
  logic [31:0] addr_q, addr_d;
  logic        ds_q, ds_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [5:0]  int_q;

  // ---------------------------------------------------------------------------
  // Interrupt line conditioning
  // ---------------------------------------------------------------------------
`ifdef EXC_IRQ_SYNC_EN
  logic [5:0] int_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_sync_q <= 6'd0;
      int_q      <= 6'd0;
    end else begin
      int_sync_q <= int_i;
      int_q      <= int_sync_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_q <= 6'd0;
    end else begin
      int_q <= int_i;
    end
  end
`endif

  assign int_o = int_q;

  // ---------------------------------------------------------------------------
  // CP0 bypass: a WB write in flight wins over the architectural value
  // ---------------------------------------------------------------------------
  logic [31:0] status_eff;
  logic [31:0] cause_eff;
  logic [31:0] epc_eff;
  logic [31:0] ebase_eff;

  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    ebase_eff  = cp0_ebase_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == AddrStatus) status_eff = wb_cp0_data_i;
      if (wb_cp0_waddr_i == AddrCause)  cause_eff  = wb_cp0_data_i;
      if (wb_cp0_waddr_i == AddrEpc)    epc_eff    = wb_cp0_data_i;
      if (wb_cp0_waddr_i == AddrEbase)  ebase_eff  = wb_cp0_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt pending: IP[7] shares the top hardware line with the timer
  // ---------------------------------------------------------------------------
  logic [7:0] ip;
  logic       irq_pend;

  assign ip       = {int_o[5] | timer_int_i, int_o[4:0], cause_eff[9:8]};
  assign irq_pend = (|(ip & status_eff[15:8])) & status_eff[0] & ~status_eff[1];

  // Bits of the effective CP0 values this block does not interpret.
  logic unused_cp0;
  assign unused_cp0 = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:10],
                        cause_eff[7:0]};

  // ---------------------------------------------------------------------------
  // Priority resolution (only meaningful in IDLE with a valid instruction)
  // ---------------------------------------------------------------------------
  logic [31:0] exc_code;

  always_comb begin
    exc_code = ExcNone;
    if (mem_valid_i) begin
      if (irq_pend)          exc_code = ExcInterrupt;
      else if (inst_inval_i) exc_code = ExcInstInval;
      else if (syscall_i)    exc_code = ExcSyscall;
      else if (trap_i)       exc_code = ExcTrap;
      else if (overflow_i)   exc_code = ExcOverflow;
      else if (eret_i)       exc_code = ExcEret;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and record capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    addr_d   = addr_q;
    ds_d     = ds_q;
    new_pc_d = new_pc_q;
    unique case (state_q)
      StIdle: begin
        if (exc_code != ExcNone) begin
          state_d  = StFlush;
          code_d   = exc_code;
          addr_d   = mem_inst_addr_i;
          ds_d     = mem_in_delayslot_i;
          new_pc_d = (exc_code == ExcEret) ? epc_eff : (ebase_eff + VecOffset);
        end
      end
      StFlush: state_d = StBlank;
      // MEM inputs are not looked at here; the flushed pipeline refills.
      StBlank: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      code_q   <= ExcNone;
      addr_q   <= 32'd0;
      ds_q     <= 1'b0;
      new_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      addr_q   <= addr_d;
      ds_q     <= ds_d;
      new_pc_q <= new_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign flush_o             = (state_q == StFlush);
  assign busy_o              = (state_q != StIdle);
  assign excepttype_o        = flush_o ? code_q : ExcNone;
  assign current_inst_addr_o = addr_q;
  assign is_in_delayslot_o   = ds_q;
  assign new_pc_o            = new_pc_q;

endmodule

// File: tb/tb_except_ctrl.sv
module tb_except_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_inst_addr_i;
  logic        mem_in_delayslot_i;
  logic        inst_inval_i;
  logic        syscall_i;
  logic        trap_i;
  logic        overflow_i;
  logic        eret_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic [31:0] cp0_ebase_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [5:0]  int_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  int checks;
  int failures;

  except_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_valid_i         (mem_valid_i),
    .mem_inst_addr_i     (mem_inst_addr_i),
    .mem_in_delayslot_i  (mem_in_delayslot_i),
    .inst_inval_i        (inst_inval_i),
    .syscall_i           (syscall_i),
    .trap_i              (trap_i),
    .overflow_i          (overflow_i),
    .eret_i              (eret_i),
    .cp0_status_i        (cp0_status_i),
    .cp0_cause_i         (cp0_cause_i),
    .cp0_epc_i           (cp0_epc_i),
    .cp0_ebase_i         (cp0_ebase_i),
    .wb_cp0_we_i         (wb_cp0_we_i),
    .wb_cp0_waddr_i      (wb_cp0_waddr_i),
    .wb_cp0_data_i       (wb_cp0_data_i),
    .int_i               (int_i),
    .timer_int_i         (timer_int_i),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .int_o               (int_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o),
    .busy_o              (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid_i        = 1'b0;
    mem_inst_addr_i    = 32'h0;
    mem_in_delayslot_i = 1'b0;
    inst_inval_i       = 1'b0;
    syscall_i          = 1'b0;
    trap_i             = 1'b0;
    overflow_i         = 1'b0;
    eret_i             = 1'b0;
    wb_cp0_we_i        = 1'b0;
    wb_cp0_waddr_i     = 5'd0;
    wb_cp0_data_i      = 32'h0;
    timer_int_i        = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    cp0_status_i = 32'h0;
    cp0_cause_i  = 32'h0;
    cp0_epc_i    = 32'h0;
    cp0_ebase_i  = 32'h8000_0000;
    int_i        = 6'h0;
    rst          = 1'b1;
    repeat (2) tick();
    checks++;
    if (flush_o !== 1'b0 || busy_o !== 1'b0 || excepttype_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_ctrl: flush=%b busy=%b code=%h, required 0 0 0",
               flush_o, busy_o, excepttype_o);
    end
    checks++;
    if (new_pc_o !== 32'h0 || current_inst_addr_o !== 32'h0 || is_in_delayslot_o !== 1'b0
        || int_o !== 6'h0) begin
      failures++;
      $display("FAIL reset_data: new_pc=%h addr=%h ds=%b int_o=%h, required all 0",
               new_pc_o, current_inst_addr_o, is_in_delayslot_o, int_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_syscall();
    clear_inputs();
    cp0_ebase_i     = 32'h8000_0000;
    mem_valid_i     = 1'b1;
    mem_inst_addr_i = 32'h8000_0100;
    syscall_i       = 1'b1;
    tick();
    checks++;
    if (excepttype_o !== 32'h8 || new_pc_o !== 32'h8000_0180 || flush_o !== 1'b1) begin
      failures++;
      $display("FAIL syscall: code=%h new_pc=%h flush=%b, required 8 80000180 1",
               excepttype_o, new_pc_o, flush_o);
    end
    checks++;
    if (current_inst_addr_o !== 32'h8000_0100 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL syscall_addr: addr=%h busy=%b, required 80000100 1",
               current_inst_addr_o, busy_o);
    end
    clear_inputs();
    tick();
    checks++;
    if (flush_o !== 1'b0 || excepttype_o !== 32'h0 || busy_o !== 1'b1
        || new_pc_o !== 32'h8000_0180) begin
      failures++;
      $display("FAIL syscall_blank: flush=%b code=%h busy=%b new_pc=%h, required 0 0 1 80000180",
               flush_o, excepttype_o, busy_o, new_pc_o);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || flush_o !== 1'b0) begin
      failures++;
      $display("FAIL syscall_idle: busy=%b flush=%b, required 0 0", busy_o, flush_o);
    end
  endtask

  task automatic test_eret_bypass();
    clear_inputs();
    cp0_epc_i       = 32'h0;
    mem_valid_i     = 1'b1;
    mem_inst_addr_i = 32'h8000_0300;
    eret_i          = 1'b1;
    wb_cp0_we_i     = 1'b1;
    wb_cp0_waddr_i  = 5'd14;
    wb_cp0_data_i   = 32'h8000_0444;
    tick();
    checks++;
    if (excepttype_o !== 32'he || new_pc_o !== 32'h8000_0444 || flush_o !== 1'b1) begin
      failures++;
      $display("FAIL eret: code=%h new_pc=%h flush=%b, required e 80000444 1",
               excepttype_o, new_pc_o, flush_o);
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_priority();
    logic [31:0] exp_code [4];
    logic [4:0]  vec [4];  // {inval, syscall, trap, overflow, eret}
    vec[0] = 5'b11111; exp_code[0] = 32'ha;
    vec[1] = 5'b01111; exp_code[1] = 32'h8;
    vec[2] = 5'b00111; exp_code[2] = 32'hd;
    vec[3] = 5'b00011; exp_code[3] = 32'hc;
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      mem_valid_i     = 1'b1;
      mem_inst_addr_i = 32'h8000_1000 + 32'(i * 4);
      {inst_inval_i, syscall_i, trap_i, overflow_i, eret_i} = vec[i];
      // Bypassed ebase must steer non-ERET vectors.
      wb_cp0_we_i     = 1'b1;
      wb_cp0_waddr_i  = 5'd15;
      wb_cp0_data_i   = 32'hbfc0_0000;
      tick();
      checks++;
      if (excepttype_o !== exp_code[i] || new_pc_o !== 32'hbfc0_0180) begin
        failures++;
        $display("FAIL priority_%0d: code=%h new_pc=%h, required %h bfc00180",
                 i, excepttype_o, new_pc_o, exp_code[i]);
      end
      clear_inputs();
      repeat (2) tick();
    end
    // No valid instruction: no exception even with faults raised.
    clear_inputs();
    syscall_i = 1'b1;
    trap_i    = 1'b1;
    tick();
    checks++;
    if (flush_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL invalid_mem: flush=%b busy=%b, required 0 0", flush_o, busy_o);
    end
    clear_inputs();
  endtask

  task automatic test_interrupt();
    clear_inputs();
    cp0_ebase_i  = 32'h8000_0000;
    cp0_status_i = 32'h0000_0401;
    int_i        = 6'h01;
    repeat (3) tick();
    checks++;
    if (int_o !== 6'h01 || flush_o !== 1'b0) begin
      failures++;
      $display("FAIL irq_no_valid: int_o=%h flush=%b, required 01 0", int_o, flush_o);
    end
    mem_valid_i        = 1'b1;
    mem_inst_addr_i    = 32'h8000_0200;
    mem_in_delayslot_i = 1'b1;
    overflow_i         = 1'b1;
    tick();
    checks++;
    if (excepttype_o !== 32'h1 || is_in_delayslot_o !== 1'b1
        || current_inst_addr_o !== 32'h8000_0200 || new_pc_o !== 32'h8000_0180) begin
      failures++;
      $display("FAIL irq: code=%h ds=%b addr=%h new_pc=%h, required 1 1 80000200 80000180",
               excepttype_o, is_in_delayslot_o, current_inst_addr_o, new_pc_o);
    end
    // Handler entry: interrupts masked, the overflow is retaken after return.
    cp0_status_i = 32'h0;
    int_i        = 6'h0;
    repeat (2) tick();
    tick();
    checks++;
    if (excepttype_o !== 32'hc || flush_o !== 1'b1) begin
      failures++;
      $display("FAIL irq_retake: code=%h flush=%b, required c 1", excepttype_o, flush_o);
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_exl_mask();
    clear_inputs();
    cp0_status_i    = 32'h0000_8003;
    timer_int_i     = 1'b1;
    mem_valid_i     = 1'b1;
    mem_inst_addr_i = 32'h8000_0500;
    tick();
    checks++;
    if (flush_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL exl_mask: flush=%b busy=%b, required 0 0", flush_o, busy_o);
    end
    trap_i = 1'b1;
    tick();
    checks++;
    if (excepttype_o !== 32'hd || flush_o !== 1'b1) begin
      failures++;
      $display("FAIL exl_trap: code=%h flush=%b, required d 1", excepttype_o, flush_o);
    end
    clear_inputs();
    cp0_status_i = 32'h0;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    int pulses;
    clear_inputs();
    pulses          = 0;
    mem_valid_i     = 1'b1;
    mem_inst_addr_i = 32'h8000_0600;
    inst_inval_i    = 1'b1;
    tick();
    checks++;
    if (excepttype_o !== 32'ha) begin
      failures++;
      $display("FAIL b2b_code: code=%h, required a", excepttype_o);
    end
    if (flush_o === 1'b1) pulses++;
    mem_inst_addr_i = 32'h8000_0604;
    tick();
    if (flush_o === 1'b1) pulses++;
    clear_inputs();
    repeat (2) begin
      tick();
      if (flush_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || current_inst_addr_o !== 32'h8000_0600) begin
      failures++;
      $display("FAIL b2b_pulses: pulses=%0d addr=%h, required 1 80000600",
               pulses, current_inst_addr_o);
    end
  endtask

  task automatic test_reset_mid_flush();
    clear_inputs();
    int_i           = 6'h3;
    mem_valid_i     = 1'b1;
    mem_inst_addr_i = 32'h8000_0700;
    mem_in_delayslot_i = 1'b1;
    syscall_i       = 1'b1;
    tick();
    checks++;
    if (flush_o !== 1'b1 || int_o !== 6'h3) begin
      failures++;
      $display("FAIL pre_rst: flush=%b int_o=%h, required 1 3", flush_o, int_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (flush_o !== 1'b0 || busy_o !== 1'b0 || excepttype_o !== 32'h0 || new_pc_o !== 32'h0
        || current_inst_addr_o !== 32'h0 || is_in_delayslot_o !== 1'b0 || int_o !== 6'h0) begin
      failures++;
      $display("FAIL rst_flush: flush=%b busy=%b code=%h pc=%h addr=%h ds=%b int_o=%h, required 0",
               flush_o, busy_o, excepttype_o, new_pc_o, current_inst_addr_o,
               is_in_delayslot_o, int_o);
    end
    rst   = 1'b0;
    int_i = 6'h0;
    tick();
    checks++;
    if (flush_o !== 1'b1 || excepttype_o !== 32'h8) begin
      failures++;
      $display("FAIL post_rst: flush=%b code=%h, required 1 8", flush_o, excepttype_o);
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_syscall();
    test_eret_bypass();
    test_priority();
    test_interrupt();
    test_exl_mask();
    test_back_to_back();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 SHALL use one clock `clk`; reset `rst` is asynchronous and active-high.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 async active-high reset.
REQ-003 SHALL have MEM-stage inputs: mem_valid_i in 1, instruction valid; mem_inst_addr_i in 32, PC; mem_in_delayslot_i in 1, delay-slot flag.
REQ-004 SHALL have MEM-stage fault inputs, in 1 each: inst_inval_i, syscall_i, trap_i, overflow_i, eret_i.
REQ-005 SHALL have CP0 state inputs, in 32 each: cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i.
REQ-006 SHALL have WB bypass inputs: wb_cp0_we_i in 1; wb_cp0_waddr_i in 5; wb_cp0_data_i in 32.
REQ-007 SHALL have interrupt inputs: int_i in 6, raw hardware lines; timer_int_i in 1, timer interrupt from CP0.
REQ-008 SHALL drive CP0-facing outputs: excepttype_o out 32; current_inst_addr_o out 32; is_in_delayslot_o out 1; int_o out 6, conditioned hardware lines.
REQ-009 SHALL drive pipeline-control outputs: flush_o out 1; new_pc_o out 32; busy_o out 1, high in FLUSH or BLANK.

Function
REQ-010 SHALL use exception codes: none 0x0, INTERRUPT 0x1, SYSCALL 0x8, INST_INVAL 0xa, OVERFLOW 0xc, TRAP 0xd, ERET 0xe.
REQ-011 SHALL take effective status/cause/epc/ebase from wb_cp0_data_i when wb_cp0_we_i=1 and waddr matches (12/13/14/15); otherwise from cp0_*_i.
REQ-012 SHALL compute IP[7:2] = int_o with bit 7 ORed with timer_int_i, and IP[1:0] = effective cause[9:8].
REQ-013 SHALL compute irq_pend = |(IP & status[15:8]) & status[0] & ~status[1].
REQ-014 SHALL resolve priority combinationally in IDLE with mem_valid_i=1: INTERRUPT > INST_INVAL > SYSCALL > TRAP > OVERFLOW > ERET.
REQ-015 SHALL, with mem_valid_i=0 in IDLE, take no exception, including when irq_pend=1.
REQ-016 SHALL use FSM states IDLE, FLUSH and BLANK.
REQ-017 SHALL, on an accepted exception in IDLE, register code, mem_inst_addr_i, mem_in_delayslot_i and new_pc, then go to FLUSH.
REQ-018 SHALL set new_pc = effective epc for ERET, and effective ebase + 0x180 for all other codes.
REQ-019 SHALL, in FLUSH, hold flush_o=1, present registered excepttype_o/current_inst_addr_o/is_in_delayslot_o/new_pc_o for exactly one cycle, then go to BLANK.
REQ-020 SHALL drive excepttype_o=0 and flush_o=0 outside FLUSH; new_pc_o holds its last value.
REQ-021 SHALL, in BLANK, ignore all MEM inputs and irq_pend for one cycle, then return to IDLE.
REQ-022 SHALL space exceptions at a minimum of 3 cycles (IDLE→FLUSH→BLANK→IDLE).
REQ-023 SHALL, when a fault and irq_pend coincide, report INTERRUPT with the faulting instruction's address; the fault is retaken after return.
REQ-024 SHALL, for ERET while status[1]=0, still report ERET and redirect to epc.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-FLUSH, asynchronously force: state IDLE; excepttype_o, current_inst_addr_o, new_pc_o = 0; is_in_delayslot_o, flush_o, busy_o = 0; int_o and synchroniser flops = 0.
REQ-026 SHALL first accept an exception on the first clk edge after rst deasserts.

Configuration
REQ-027 SHALL compile a two-flop synchroniser int_i→int_o (2-cycle latency) when macro EXC_IRQ_SYNC_EN is defined.
REQ-028 SHALL, without EXC_IRQ_SYNC_EN, register int_o from int_i once (1-cycle latency); all other behaviour is identical.

Verification
REQ-029 SHALL test: syscall_i=1, addr 0x80000100, ebase 0x80000000 → next cycle excepttype_o=0x8, new_pc_o=0x80000180, flush_o=1 for 1 cycle.
REQ-030 SHALL test: eret_i=1 with wb_cp0_we_i=1, waddr=14, data 0x80000444 (cp0_epc_i=0) → new_pc_o=0x80000444, code 0xe.
REQ-031 SHALL test: status=0x0000_0401, int_i[0]=1, overflow_i=1, delayslot=1 → excepttype_o=0x1, is_in_delayslot_o=1.
REQ-032 SHALL test: status[1]=1 (EXL) with timer_int_i=1 and IM7 set → no exception; trap_i then gives 0xd.
REQ-033 SHALL test: back-to-back inst_inval_i on consecutive cycles → one pulse, BLANK suppresses the second; rst in FLUSH → all outputs 0 immediately.
